// File: rtl/io_write_burst_engine.sv
// Write-side burst DMA: buffers result words and issues address/data/status bursts.
// Optional perf counters (perf_cycles, perf_stall) when IO_WRITE_PERF_EN is defined.
module io_write_burst_engine #(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [31:0]       total_len,
    output logic              busy,
    output logic              done,
    output logic              wr_error,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [AWIDTH-1:0] req_write_addr,
    output logic [31:0]       req_write_len,
    output logic              req_write_addr_valid,
    input  logic              req_write_addr_ready,
    output logic [DWIDTH-1:0] req_write_data,
    output logic              req_write_data_valid,
    input  logic              req_write_data_ready,
    input  logic              resp_write_status,
    input  logic              resp_write_status_valid,
    output logic              resp_write_status_ready
`ifdef IO_WRITE_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stall
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ADDR,
        DATA,
        RESP,
        DONE
    } state_t;

    state_t            state;
    logic [DWIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic [31:0]       len_q;
    logic [31:0]       accepted;
    logic [31:0]       issued;
    logic [31:0]       beats;
    logic [31:0]       remain;
    logic [31:0]       blen;
    logic [AWIDTH-1:0] cur_addr;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // Never accept more words than the job needs, so the FIFO only ever
    // holds words of the current job.
    assign in_ready = busy & ~fifo_full & (accepted < len_q);
    assign push     = in_valid & in_ready;

    assign req_write_data_valid = (state == DATA) & ~fifo_empty;
    assign req_write_data = req_write_data_valid ? mem[rd_ptr] : '0;
    assign pop = req_write_data_valid & req_write_data_ready;

    assign remain = len_q - issued;
    assign blen   = (remain > 32'(BURST_LEN)) ? 32'(BURST_LEN) : remain;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= IDLE;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            wr_error                <= 1'b0;
            len_q                   <= '0;
            accepted                <= '0;
            issued                  <= '0;
            beats                   <= '0;
            cur_addr                <= '0;
            req_write_addr          <= '0;
            req_write_len           <= '0;
            req_write_addr_valid    <= 1'b0;
            resp_write_status_ready <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) begin
                accepted <= accepted + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= total_len;
                        cur_addr <= base_addr;
                        issued   <= '0;
                        accepted <= '0;
                        busy     <= 1'b1;
                        wr_error <= 1'b0;
                        state    <= (total_len == '0) ? DONE : FILL;
                    end
                end
                // Whole burst must be buffered before the request goes out.
                FILL: begin
                    if (32'(count) >= blen) begin
                        req_write_addr       <= cur_addr;
                        req_write_len        <= blen;
                        req_write_addr_valid <= 1'b1;
                        state                <= ADDR;
                    end
                end
                ADDR: begin
                    if (req_write_addr_ready) begin
                        req_write_addr_valid <= 1'b0;
                        beats                <= '0;
                        state                <= DATA;
                    end
                end
                DATA: begin
                    if (pop) begin
                        beats <= beats + 32'd1;
                        if (beats + 32'd1 == req_write_len) begin
                            cur_addr <= cur_addr + AWIDTH'(req_write_len);
                            issued   <= issued + req_write_len;
                            resp_write_status_ready <= 1'b1;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (resp_write_status_valid) begin
                        resp_write_status_ready <= 1'b0;
                        if (!resp_write_status) begin
                            wr_error <= 1'b1;
                        end
                        state <= (issued == len_q) ? DONE : FILL;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IO_WRITE_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else begin
            if (busy && perf_cycles != '1) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if (req_write_data_valid && !req_write_data_ready
                && perf_stall != '1) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_io_write_burst_engine.sv
// Scoreboard bench for io_write_burst_engine: bursts, data order, status and reset.
module tb_io_write_burst_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] total_len;
    logic        busy;
    logic        done;
    logic        wr_error;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] req_write_addr;
    logic [31:0] req_write_len;
    logic        req_write_addr_valid;
    logic        req_write_addr_ready;
    logic [31:0] req_write_data;
    logic        req_write_data_valid;
    logic        req_write_data_ready;
    logic        resp_write_status;
    logic        resp_write_status_valid;
    logic        resp_write_status_ready;
`ifdef IO_WRITE_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stall;
`endif

    io_write_burst_engine dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .base_addr               (base_addr),
        .total_len               (total_len),
        .busy                    (busy),
        .done                    (done),
        .wr_error                (wr_error),
        .in_data                 (in_data),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .req_write_addr          (req_write_addr),
        .req_write_len           (req_write_len),
        .req_write_addr_valid    (req_write_addr_valid),
        .req_write_addr_ready    (req_write_addr_ready),
        .req_write_data          (req_write_data),
        .req_write_data_valid    (req_write_data_valid),
        .req_write_data_ready    (req_write_data_ready),
        .resp_write_status       (resp_write_status),
        .resp_write_status_valid (resp_write_status_valid),
        .resp_write_status_ready (resp_write_status_ready)
`ifdef IO_WRITE_PERF_EN
        ,
        .perf_cycles             (perf_cycles),
        .perf_stall              (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [63:0] exp_burst[$];
    logic [31:0] exp_data[$];
    logic [63:0] eb;
    int          cyc = 0;
    int          in_acc = 0;
    int          occ = 0;
    int          pop_cnt = 0;
    int          burst_cnt = 0;
    int          done_cnt = 0;
    int          av_cnt = 0;
    int          resp_idx = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    int          in_mode = 0;
    int          rmode = 0;
    int          bad_burst = 0;
    logic        in_burst = 1'b0;
    logic        resp_owed = 1'b0;
    logic        err_at_done = 1'b0;
    logic [31:0] cur_len = '0;
    logic [31:0] beats = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: all handshakes sampled mid-cycle, predicting the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            exp_burst.delete();
            exp_data.delete();
            in_burst  = 1'b0;
            resp_owed = 1'b0;
            beats     = '0;
            occ       = 0;
        end else begin
            if (start && !busy) resp_idx = 0;
            if (req_write_addr_valid) av_cnt++;
            if (in_burst) chk("dvalid", req_write_data_valid, 1'b1);
            if (req_write_addr_valid && req_write_addr_ready) begin
                burst_cnt++;
                if (exp_burst.size() == 0) begin
                    chk("unexp_addr", 1'b1, 1'b0);
                end else begin
                    eb = exp_burst.pop_front();
                    chk("addr", req_write_addr, eb[63:32]);
                    chk("len", req_write_len, eb[31:0]);
                end
                chk("fill", occ >= int'(req_write_len), 1'b1);
                cur_len  = req_write_len;
                beats    = '0;
                in_burst = 1'b1;
            end
            if (in_valid && in_ready) begin
                exp_data.push_back(in_data);
                in_acc++;
                occ++;
            end
            if (req_write_data_valid && req_write_data_ready) begin
                chk("data_in_burst", in_burst, 1'b1);
                if (exp_data.size() == 0) begin
                    chk("unexp_data", 1'b1, 1'b0);
                end else begin
                    chk("data", req_write_data, exp_data.pop_front());
                end
                pop_cnt++;
                occ--;
                beats = beats + 32'd1;
                if (beats == cur_len) begin
                    in_burst  = 1'b0;
                    resp_owed = 1'b1;
                end
            end
            if (resp_write_status_valid && resp_write_status_ready) begin
                resp_owed = 1'b0;
                resp_idx++;
            end
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                err_at_done = wr_error;
            end
        end
    end

    // Source and controller models, driven just after the edge.
    always @(posedge clk) begin
        #1;
        in_valid = (in_mode == 1) || (in_mode == 3 && cyc % 3 == 0);
        in_data  = 32'hA500_0000 + 32'(in_acc);
        req_write_addr_ready = (rmode == 0) || ($urandom_range(0, 1) == 1);
        req_write_data_ready = (rmode == 0) || ($urandom_range(0, 1) == 1);
        resp_write_status_valid = resp_owed;
        resp_write_status = (resp_idx + 1 != bad_burst);
    end

    task automatic push_bursts(input logic [31:0] base,
                               input logic [31:0] len, output int nb);
        logic [31:0] rem;
        logic [31:0] a;
        logic [31:0] bl;
        rem = len;
        a   = base;
        nb  = 0;
        while (rem != 0) begin
            bl = (rem > 32'd16) ? 32'd16 : rem;
            exp_burst.push_back({a, bl});
            a   = a + bl;
            rem = rem - bl;
            nb++;
        end
    endtask

    task automatic run_job(input logic [31:0] base, input logic [31:0] len,
                           input int imode, input int rm, input int bad,
                           input logic exp_err);
        int d0;
        int p0;
        int b0;
        int nb;
        int n;
        d0 = done_cnt;
        p0 = pop_cnt;
        b0 = burst_cnt;
        push_bursts(base, len, nb);
        @(posedge clk);
        #1;
        in_mode   = imode;
        rmode     = rm;
        bad_burst = bad;
        base_addr = base;
        total_len = len;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        chk("timeout", n < 4000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("pops", pop_cnt - p0, len);
        chk("bursts", burst_cnt - b0, nb);
        chk("wr_error", err_at_done, exp_err);
        chk("sb_left", exp_burst.size() + exp_data.size(), 0);
        chk("busy_low", busy, 1'b0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk(tag, {busy, done, wr_error, in_ready, req_write_addr_valid,
                  req_write_data_valid, resp_write_status_ready}, 0);
        chk({tag, "_bus"}, {req_write_addr, req_write_len}, 0);
        chk({tag, "_data"}, req_write_data, 0);
    endtask

    initial begin
        int a0;
        int d0;
        int p0;
        int nb;
        int n;
        rst = 1'b0;
        start = 1'b0;
        base_addr = '0;
        total_len = '0;
        in_valid = 1'b0;
        in_data = '0;
        req_write_addr_ready = 1'b0;
        req_write_data_ready = 1'b0;
        resp_write_status = 1'b0;
        resp_write_status_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b1;

        run_job(32'h100, 32'd16, 1, 0, 0, 1'b0);
        run_job(32'h100, 32'd40, 1, 0, 0, 1'b0);
        run_job(32'h300, 32'd40, 1, 1, 0, 1'b0);
        run_job(32'h100, 32'd40, 3, 0, 0, 1'b0);
        run_job(32'h100, 32'd40, 1, 0, 2, 1'b1);

        a0 = av_cnt;
        run_job(32'h100, 32'd0, 1, 0, 0, 1'b0);
        chk("len0_lat", done_cyc - start_cyc, 2);
        chk("len0_noaddr", av_cnt - a0, 0);

        run_job(32'hFFFF_FFF8, 32'd20, 1, 0, 0, 1'b0);

        // Abort a job mid-burst, then run a short job from clean state.
        d0 = done_cnt;
        p0 = pop_cnt;
        push_bursts(32'h500, 32'd40, nb);
        @(posedge clk);
        #1;
        in_mode   = 1;
        rmode     = 0;
        bad_burst = 0;
        base_addr = 32'h500;
        total_len = 32'd40;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (pop_cnt - p0 < 5 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("abort_reach", n < 1000, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("abort_nodone", done_cnt - d0, 0);
        run_job(32'h200, 32'd4, 1, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
